ed25519_msg_loader: RTL and testbench

- Upstream front-end for the Ed25519/SHAKE128 signer.
- Accepts the message as a byte stream using valid/ready with a last marker.
- Packs the bytes little-endian into a 256-bit message word with a byte length, pulses the signer's start, then holds the operands stable until the signer reports done.
- Rejects messages longer than 32 bytes and flushes them.

---
 rtl/ed25519_msg_loader.sv | 177 +++++++++++++++++
 tb/tb_ed25519_msg_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ed25519_msg_loader.sv
// Byte-stream front-end for the Ed25519/SHAKE128 signer: packs up to MAX_BYTES bytes
// little-endian into a 256-bit word, launches the signer and holds operands until done.
// Optional inter-byte idle timeout: define ED25519_LOADER_TIMEOUT_EN (adds err_timeout).
module ed25519_msg_loader #(
  parameter int MAX_BYTES      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  input  logic         s_last,
  input  logic         s_empty,
  output logic         s_ready,
  output logic [255:0] msg,
  output logic [6:0]   msg_len,
  output logic         sign_start,
  input  logic         sign_done,
  output logic         busy,
  output logic         err_overflow
`ifdef ED25519_LOADER_TIMEOUT_EN
  ,
  output logic         err_timeout
`endif
);

  if (MAX_BYTES < 1 || MAX_BYTES > 32 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ed25519_msg_loader: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_COLLECT,
    S_DRAIN,
    S_LAUNCH,
    S_WAIT
  } state_e;

  localparam logic [5:0] MAX_CNT = 6'(MAX_BYTES);

  state_e         state_q, state_d;
  logic [255:0]   msg_q, msg_d;
  logic [6:0]     msg_len_q, msg_len_d;
  logic [5:0]     count_q, count_d;
  logic           s_ready_q, s_ready_d;
  logic           sign_start_q, sign_start_d;
  logic           busy_q, busy_d;
  logic           err_overflow_q, err_overflow_d;
  logic           accept;

`ifdef ED25519_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] idle_q, idle_d;
  logic            err_timeout_q, err_timeout_d;
  logic            idle_run;
`endif

  assign accept = s_valid & s_ready_q;

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d        = state_q;
    msg_d          = msg_q;
    msg_len_d      = msg_len_q;
    count_d        = count_q;
    err_overflow_d = 1'b0;

    unique case (state_q)
      S_COLLECT: begin
        if (accept) begin
          if (s_last && s_empty) begin
            msg_len_d = 7'(count_q);
            state_d   = S_LAUNCH;
          end else if (count_q == MAX_CNT) begin
            // Byte MAX_BYTES+1: drop everything collected so far.
            msg_d     = '0;
            msg_len_d = '0;
            count_d   = '0;
            if (s_last) err_overflow_d = 1'b1;
            else        state_d        = S_DRAIN;
          end else begin
            msg_d[{count_q[4:0], 3'b000} +: 8] = s_data;
            count_d = count_q + 6'd1;
            if (s_last) begin
              msg_len_d = 7'(count_q) + 7'd1;
              state_d   = S_LAUNCH;
            end
          end
        end
      end
      S_DRAIN: begin
        if (accept && s_last) begin
          err_overflow_d = 1'b1;
          state_d        = S_COLLECT;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (sign_done) begin
          msg_d     = '0;
          msg_len_d = '0;
          count_d   = '0;
          state_d   = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase

`ifdef ED25519_LOADER_TIMEOUT_EN
    err_timeout_d = 1'b0;
    idle_run      = (state_q == S_COLLECT && count_q != 6'd0) || (state_q == S_DRAIN);
    if (!idle_run || accept) begin
      idle_d = '0;
    end else if (idle_q == TO_LAST) begin
      idle_d        = '0;
      msg_d         = '0;
      msg_len_d     = '0;
      count_d       = '0;
      state_d       = S_COLLECT;
      err_timeout_d = 1'b1;
    end else begin
      idle_d = idle_q + 1'b1;
    end
`endif

    // Handshake/status outputs are registered from the next state.
    s_ready_d    = (state_d == S_COLLECT) || (state_d == S_DRAIN);
    busy_d       = (state_d == S_LAUNCH)  || (state_d == S_WAIT);
    sign_start_d = (state_d == S_LAUNCH);
  end

  // NOTE: state uses non-blocking assignments; the 256-bit message register is reset too,
  // because cleared lanes are what guarantee unused bytes read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_COLLECT;
      msg_q          <= '0;
      msg_len_q      <= '0;
      count_q        <= '0;
      s_ready_q      <= 1'b0;
      sign_start_q   <= 1'b0;
      busy_q         <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      msg_q          <= msg_d;
      msg_len_q      <= msg_len_d;
      count_q        <= count_d;
      s_ready_q      <= s_ready_d;
      sign_start_q   <= sign_start_d;
      busy_q         <= busy_d;
      err_overflow_q <= err_overflow_d;
    end
  end

`ifdef ED25519_LOADER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      idle_q        <= idle_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`endif

  assign s_ready      = s_ready_q;
  assign msg          = msg_q;
  assign msg_len      = msg_len_q;
  assign sign_start   = sign_start_q;
  assign busy         = busy_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_ed25519_msg_loader.sv
// Randomized self-checking bench for ed25519_msg_loader: each message's outcome is
// predicted from its length and bytes alone (legal -> packed word, oversize -> error pulse).
module tb_ed25519_msg_loader;

  localparam int MAX_BYTES = 32;
  localparam int TO_CYC    = 16;

  typedef logic [7:0] byte_q_t[$];

  logic         clk;
  logic         rst_n;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_last;
  logic         s_empty;
  logic         s_ready;
  logic [255:0] msg;
  logic [6:0]   msg_len;
  logic         sign_start;
  logic         sign_done;
  logic         busy;
  logic         err_overflow;
`ifdef ED25519_LOADER_TIMEOUT_EN
  logic         err_timeout;
`endif

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int ovf_cnt = 0;
  int clash_cnt = 0;

  ed25519_msg_loader #(
    .MAX_BYTES      (MAX_BYTES),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_empty      (s_empty),
    .s_ready      (s_ready),
    .msg          (msg),
    .msg_len      (msg_len),
    .sign_start   (sign_start),
    .sign_done    (sign_done),
    .busy         (busy),
    .err_overflow (err_overflow)
`ifdef ED25519_LOADER_TIMEOUT_EN
    ,
    .err_timeout  (err_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sign_start) start_cnt++;
      if (err_overflow) ovf_cnt++;
      if (sign_start && err_overflow) clash_cnt++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one beat and returns at the negedge after it was accepted.
  task automatic drive_beat(input logic [7:0] d, input logic last, input logic empty);
    int w = 0;
    while (!s_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("s_ready_before_beat", s_ready, 1'b1);
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    s_empty = empty;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_empty = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic send_msg(input byte_q_t bytes, input bit empty_last);
    int n = bytes.size();
    for (int i = 0; i < n; i++) begin
      logic last_b;
      logic empty_b;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      last_b  = !empty_last && (i == n - 1);
      // s_empty without s_last must be ignored, so sprinkle it on middle beats.
      empty_b = last_b ? 1'b0 : 1'($urandom_range(0, 3) == 0);
      drive_beat(bytes[i], last_b, empty_b);
    end
    if (empty_last) drive_beat(8'($urandom), 1'b1, 1'b1);
  endtask

  task automatic run_msg(input byte_q_t bytes, input bit empty_last);
    int           n = bytes.size();
    int           s0 = start_cnt;
    int           o0 = ovf_cnt;
    logic [255:0] exp_msg = '0;
    for (int i = 0; i < n && i < MAX_BYTES; i++) exp_msg[8*i +: 8] = bytes[i];
    send_msg(bytes, empty_last);
    if (n <= MAX_BYTES) begin
      check("sign_start_pulse", sign_start, 1'b1);
      check("busy_launch", busy, 1'b1);
      check("s_ready_launch", s_ready, 1'b0);
      check("msg_value", msg, exp_msg);
      check("msg_len_value", msg_len, 7'(n));
      @(negedge clk);
      check("sign_start_one_cycle", sign_start, 1'b0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      check("msg_held", msg, exp_msg);
      check("msg_len_held", msg_len, 7'(n));
      check("busy_wait", busy, 1'b1);
      check("s_ready_wait", s_ready, 1'b0);
      sign_done = 1'b1;
      @(negedge clk);
      sign_done = 1'b0;
      check("busy_after_done", busy, 1'b0);
      check("s_ready_after_done", s_ready, 1'b1);
      check("msg_cleared", msg, 256'd0);
      @(negedge clk);
      check("start_count", 32'(start_cnt - s0), 32'd1);
      check("ovf_count", 32'(ovf_cnt - o0), 32'd0);
    end else begin
      check("err_overflow_pulse", err_overflow, 1'b1);
      check("no_start_on_ovf", sign_start, 1'b0);
      check("s_ready_after_ovf", s_ready, 1'b1);
      @(negedge clk);
      check("err_overflow_one_cycle", err_overflow, 1'b0);
      check("start_count_ovf", 32'(start_cnt - s0), 32'd0);
      check("ovf_count_ovf", 32'(ovf_cnt - o0), 32'd1);
    end
  endtask

  initial begin
    byte_q_t q;
    int      s0;

    rst_n     = 1'b0;
    s_data    = '0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    s_empty   = 1'b0;
    sign_done = 1'b0;
    #12;
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_msg", msg, 256'd0);
    check("rst_msg_len", msg_len, 7'd0);
    check("rst_sign_start", sign_start, 1'b0);
    check("rst_err_overflow", err_overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    q = '{8'h61, 8'h62, 8'h63};
    run_msg(q, 1'b0);

    q = {};
    run_msg(q, 1'b1);

    q = {};
    for (int i = 0; i < 32; i++) q.push_back(8'(i));
    run_msg(q, 1'b0);
    run_msg(q, 1'b1);

    q = {};
    for (int i = 0; i < 40; i++) q.push_back(8'($urandom));
    run_msg(q, 1'b0);
    q = '{8'hAA};
    run_msg(q, 1'b0);

    q = {};
    for (int i = 0; i < 33; i++) q.push_back(8'($urandom));
    run_msg(q, 1'b0);
    run_msg(q, 1'b1);

    for (int it = 0; it < 25; it++) begin
      int r = $urandom_range(0, 9);
      int len;
      bit el;
      if (r < 6)       len = $urandom_range(1, 31);
      else if (r == 6) len = 0;
      else if (r == 7) len = 32;
      else if (r == 8) len = 33;
      else             len = $urandom_range(34, 40);
      el = (len == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) begin
        sign_done = 1'b1;
        @(negedge clk);
        sign_done = 1'b0;
        check("done_ignored_idle_busy", busy, 1'b0);
        check("done_ignored_idle_ready", s_ready, 1'b1);
      end
      q = {};
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      run_msg(q, el);
    end

    // Asynchronous reset while waiting for the signer.
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_msg(q, 1'b0);
    @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_s_ready", s_ready, 1'b0);
    check("mid_rst_msg", msg, 256'd0);
    check("mid_rst_msg_len", msg_len, 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = start_cnt;
    @(negedge clk);
    sign_done = 1'b1;
    @(negedge clk);
    sign_done = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_s_ready", s_ready, 1'b1);
    check("post_rst_no_start", 32'(start_cnt - s0), 32'd0);
    q = '{8'h5A, 8'hC3};
    run_msg(q, 1'b0);

`ifdef ED25519_LOADER_TIMEOUT_EN
    begin
      int n_idle = 0;
      s0 = start_cnt;
      drive_beat(8'h11, 1'b0, 1'b0);
      drive_beat(8'h22, 1'b0, 1'b0);
      while (!err_timeout && n_idle < 40) begin
        @(negedge clk);
        n_idle++;
      end
      check("timeout_idle_cycles", 32'(n_idle), 32'(TO_CYC));
      check("timeout_msg_cleared", msg, 256'd0);
      @(negedge clk);
      check("timeout_one_cycle", err_timeout, 1'b0);
      check("timeout_no_start", 32'(start_cnt - s0), 32'd0);
      q = '{8'h55};
      run_msg(q, 1'b0);
    end
`endif

    check("no_start_ovf_clash", 32'(clash_cnt), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
